// File: rtl/vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// vga_timing_monitor
//
// Receive-side companion of an XVGA-style timing generator. Samples hsync,
// vsync and blank in the pixel-clock domain, rebuilds the pixel coordinates,
// measures line/frame geometry, declares lock once the timing has been stable
// for LOCK_FRAMES consecutive clean frames and pulses timing_err when the
// timing changes while locked.
//
// Ports
//   vclock       in   pixel clock, sole clock
//   reset_n      in   asynchronous active-low reset
//   hsync        in   horizontal sync, active low
//   vsync        in   vertical sync, active low
//   blank        in   1 = blanking, 0 = active pixel
//   pixel_valid  out  registered ~blank
//   x            out  pixel index within the active line
//   y            out  active-line index within the frame
//   htotal       out  cycles between consecutive hsync falling edges
//   hactive      out  unblanked cycles in the last line that had any
//   hsync_width  out  cycles hsync was low in the last pulse
//   vtotal       out  hsync falling edges between consecutive vsync falls
//   vactive      out  lines with at least one active cycle in last frame
//   locked       out  timing stable
//   timing_err   out  one-cycle pulse on a mismatch while locked
// -----------------------------------------------------------------------------
module vga_timing_monitor #(
    parameter int HBITS       = 11,
    parameter int VBITS       = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             vclock,
    input  logic             reset_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank,
    output logic             pixel_valid,
    output logic [HBITS-1:0] x,
    output logic [VBITS-1:0] y,
    output logic [HBITS-1:0] htotal,
    output logic [HBITS-1:0] hactive,
    output logic [HBITS-1:0] hsync_width,
    output logic [VBITS-1:0] vtotal,
    output logic [VBITS-1:0] vactive,
    output logic             locked,
    output logic             timing_err
);

    localparam logic [HBITS-1:0] H_ZERO = {HBITS{1'b0}};
    localparam logic [HBITS-1:0] H_ONE  = {{(HBITS-1){1'b0}}, 1'b1};
    localparam logic [HBITS-1:0] H_MAX  = {HBITS{1'b1}};
    localparam logic [VBITS-1:0] V_ZERO = {VBITS{1'b0}};
    localparam logic [VBITS-1:0] V_ONE  = {{(VBITS-1){1'b0}}, 1'b1};
    localparam logic [VBITS-1:0] V_MAX  = {VBITS{1'b1}};
    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_FRAMES);

    // Saturating increment for horizontal-width quantities.
    function automatic logic [HBITS-1:0] h_sat_inc(input logic [HBITS-1:0] v);
        logic [HBITS-1:0] r;
        if (v == H_MAX) begin
            r = v;
        end else begin
            r = v + H_ONE;
        end
        return r;
    endfunction

    // Saturating increment for vertical-width quantities.
    function automatic logic [VBITS-1:0] v_sat_inc(input logic [VBITS-1:0] v);
        logic [VBITS-1:0] r;
        if (v == V_MAX) begin
            r = v;
        end else begin
            r = v + V_ONE;
        end
        return r;
    endfunction

    // Previous-cycle samples of the raw inputs (reset to 1: no edge on release)
    logic hsync_prev_q, vsync_prev_q, blank_prev_q;

    // Internal counters
    logic [HBITS-1:0] hcnt_q,  hcnt_d;
    logic [HBITS-1:0] swcnt_q, swcnt_d;
    logic [HBITS-1:0] acnt_q,  acnt_d;
    logic [VBITS-1:0] vcnt_q,  vcnt_d;
    logic [HBITS-1:0] xc_q,    xc_d;
    logic [VBITS-1:0] yc_q,    yc_d;
    logic [3:0]       lockcnt_q, lockcnt_d;
    logic             frame_dirty_q, frame_dirty_d;

    // Registered outputs
    logic             pixel_valid_q, pixel_valid_d;
    logic [HBITS-1:0] x_q, x_d;
    logic [VBITS-1:0] y_q, y_d;
    logic [HBITS-1:0] htotal_q, htotal_d;
    logic [HBITS-1:0] hactive_q, hactive_d;
    logic [HBITS-1:0] hsync_width_q, hsync_width_d;
    logic [VBITS-1:0] vtotal_q, vtotal_d;
    logic [VBITS-1:0] vactive_q, vactive_d;
    logic             locked_q, locked_d;
    logic             timing_err_q, timing_err_d;

    // Edge strobes and mismatch flags
    logic             hfall_s, hrise_s, vfall_s, arun_end_s;
    logic [HBITS-1:0] htotal_new_s;
    logic [VBITS-1:0] vtotal_new_s;
    logic             line_mis_s, frame_mis_s, any_mis_s, frame_clean_s;

    // Edge detection on raw inputs against last cycle's samples.
    always_comb begin
        hfall_s    = hsync_prev_q & ~hsync;
        hrise_s    = ~hsync_prev_q & hsync;
        vfall_s    = vsync_prev_q & ~vsync;
        arun_end_s = ~blank_prev_q & blank;
    end

    // Horizontal measurements: line period, sync width, active run length.
    always_comb begin
        htotal_new_s  = h_sat_inc(hcnt_q);
        hcnt_d        = hcnt_q;
        swcnt_d       = swcnt_q;
        acnt_d        = acnt_q;
        htotal_d      = htotal_q;
        hactive_d     = hactive_q;
        hsync_width_d = hsync_width_q;
        line_mis_s    = 1'b0;

        if (hfall_s) begin
            hcnt_d     = H_ZERO;
            htotal_d   = htotal_new_s;
            line_mis_s = (htotal_new_s != htotal_q);
        end else begin
            hcnt_d     = h_sat_inc(hcnt_q);
            // Flag only the step onto the saturation value, so a stuck
            // hsync reports once rather than every cycle.
            line_mis_s = (hcnt_q == (H_MAX - H_ONE));
        end

        if (hrise_s) begin
            hsync_width_d = swcnt_q;
            swcnt_d       = H_ZERO;
        end else if (!hsync) begin
            swcnt_d = h_sat_inc(swcnt_q);
        end else begin
            swcnt_d = swcnt_q;
        end

        // Lines that were fully blanked leave the last hactive untouched.
        if (hfall_s) begin
            if (acnt_q != H_ZERO) begin
                hactive_d = acnt_q;
            end else begin
                hactive_d = hactive_q;
            end
            acnt_d = blank ? H_ZERO : H_ONE;
        end else if (!blank) begin
            acnt_d = h_sat_inc(acnt_q);
        end else begin
            acnt_d = acnt_q;
        end
    end

    // Vertical measurements: lines per frame and active lines per frame.
    always_comb begin
        // An hfall coinciding with vfall belongs to the frame that is closing.
        if (hfall_s) begin
            vtotal_new_s = v_sat_inc(vcnt_q);
        end else begin
            vtotal_new_s = vcnt_q;
        end
        vcnt_d      = vcnt_q;
        vtotal_d    = vtotal_q;
        vactive_d   = vactive_q;
        frame_mis_s = 1'b0;

        if (vfall_s) begin
            vcnt_d      = V_ZERO;
            vtotal_d    = vtotal_new_s;
            frame_mis_s = (vtotal_new_s != vtotal_q);
            if (arun_end_s) begin
                vactive_d = v_sat_inc(yc_q);
            end else begin
                vactive_d = yc_q;
            end
        end else if (hfall_s) begin
            vcnt_d      = v_sat_inc(vcnt_q);
            frame_mis_s = (vcnt_q == (V_MAX - V_ONE));
        end else begin
            vcnt_d = vcnt_q;
        end
    end

    // Coordinate recovery: x counts active cycles, y counts ended active runs.
    always_comb begin
        pixel_valid_d = ~blank;
        y_d           = yc_q;
        if (blank) begin
            xc_d = H_ZERO;
            x_d  = H_ZERO;
        end else begin
            xc_d = h_sat_inc(xc_q);
            x_d  = xc_q;
        end

        // Frame start clears the line index even if a run ends that cycle.
        if (vfall_s) begin
            yc_d = V_ZERO;
        end else if (arun_end_s) begin
            yc_d = v_sat_inc(yc_q);
        end else begin
            yc_d = yc_q;
        end
    end

    // Lock qualification and error reporting.
    always_comb begin
        any_mis_s     = line_mis_s | frame_mis_s;
        frame_clean_s = ~frame_dirty_q & ~any_mis_s;
        timing_err_d  = any_mis_s & locked_q;
        lockcnt_d     = lockcnt_q;
        frame_dirty_d = frame_dirty_q;

        if (vfall_s) begin
            frame_dirty_d = 1'b0;
            if (!frame_clean_s) begin
                lockcnt_d = 4'd0;
            end else if (lockcnt_q == LOCK_TARGET) begin
                lockcnt_d = lockcnt_q;
            end else begin
                lockcnt_d = lockcnt_q + 4'd1;
            end
        end else if (any_mis_s) begin
            frame_dirty_d = 1'b1;
            // Losing lock restarts qualification immediately.
            if (locked_q) begin
                lockcnt_d = 4'd0;
            end else begin
                lockcnt_d = lockcnt_q;
            end
        end else begin
            lockcnt_d = lockcnt_q;
        end

        locked_d = (lockcnt_d == LOCK_TARGET);
    end

    // State and output registers.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_prev_q  <= 1'b1;
            vsync_prev_q  <= 1'b1;
            blank_prev_q  <= 1'b1;
            hcnt_q        <= H_ZERO;
            swcnt_q       <= H_ZERO;
            acnt_q        <= H_ZERO;
            vcnt_q        <= V_ZERO;
            xc_q          <= H_ZERO;
            yc_q          <= V_ZERO;
            lockcnt_q     <= 4'd0;
            frame_dirty_q <= 1'b0;
            pixel_valid_q <= 1'b0;
            x_q           <= H_ZERO;
            y_q           <= V_ZERO;
            htotal_q      <= H_ZERO;
            hactive_q     <= H_ZERO;
            hsync_width_q <= H_ZERO;
            vtotal_q      <= V_ZERO;
            vactive_q     <= V_ZERO;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            hsync_prev_q  <= hsync;
            vsync_prev_q  <= vsync;
            blank_prev_q  <= blank;
            hcnt_q        <= hcnt_d;
            swcnt_q       <= swcnt_d;
            acnt_q        <= acnt_d;
            vcnt_q        <= vcnt_d;
            xc_q          <= xc_d;
            yc_q          <= yc_d;
            lockcnt_q     <= lockcnt_d;
            frame_dirty_q <= frame_dirty_d;
            pixel_valid_q <= pixel_valid_d;
            x_q           <= x_d;
            y_q           <= y_d;
            htotal_q      <= htotal_d;
            hactive_q     <= hactive_d;
            hsync_width_q <= hsync_width_d;
            vtotal_q      <= vtotal_d;
            vactive_q     <= vactive_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign htotal      = htotal_q;
    assign hactive     = hactive_q;
    assign hsync_width = hsync_width_q;
    assign vtotal      = vtotal_q;
    assign vactive     = vactive_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for vga_timing_monitor. A short table of hand-computed vectors
// checks the per-cycle behaviour out of reset; a reduced-size raster generator
// (same structure as 1024x768 XVGA, scaled so whole frames are short) drives
// the multi-frame lock, error and reset scenarios.
// -----------------------------------------------------------------------------
module tb_vga_timing_monitor;

    localparam int HBITS = 11;
    localparam int VBITS = 10;

    // Scaled raster: 100 cycles/line, 64 active, hsync low 12 cycles;
    // 10 lines/frame, 6 active, vsync low 2 lines.
    localparam int H_TOTAL      = 100;
    localparam int H_ACT        = 64;
    localparam int H_SYNC_START = 68;
    localparam int H_SYNC_LEN   = 12;
    localparam int V_TOTAL      = 10;
    localparam int V_ACT        = 6;
    localparam int V_SYNC_START = 7;
    localparam int V_SYNC_LEN   = 2;
    localparam int RUN_LIMIT    = 5000;

    logic             vclock;
    logic             reset_n;
    logic             hsync, vsync, blank;
    logic             pixel_valid;
    logic [HBITS-1:0] x, htotal, hactive, hsync_width;
    logic [VBITS-1:0] y, vtotal, vactive;
    logic             locked, timing_err;

    int checks = 0;
    int errors = 0;

    vga_timing_monitor #(.HBITS(HBITS), .VBITS(VBITS), .LOCK_FRAMES(2)) dut (
        .vclock      (vclock),
        .reset_n     (reset_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .pixel_valid (pixel_valid),
        .x           (x),
        .y           (y),
        .htotal      (htotal),
        .hactive     (hactive),
        .hsync_width (hsync_width),
        .vtotal      (vtotal),
        .vactive     (vactive),
        .locked      (locked),
        .timing_err  (timing_err)
    );

    initial vclock = 1'b0;
    always #5 vclock = ~vclock;

    typedef struct {
        logic             h, v, b;
        logic             pv;
        logic [HBITS-1:0] x;
        logic [VBITS-1:0] y;
        logic [HBITS-1:0] ht, ha, hw;
        logic [VBITS-1:0] vt, va;
    } vec_t;

    vec_t vecs[12];

    // Generator state
    int hc = 0, vc = 0, hlen = H_TOTAL, vlen = V_TOTAL, idle_left = 0;
    logic prev_h = 1'b1, prev_v = 1'b1;
    int hfall_cnt = 0, vfall_cnt = 0, since_hfall = 0;
    int err_pulses = 0, err_since = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout, got no event expected one", name);
    endtask

    task automatic set_vec(input int i, input logic h, input logic v, input logic b,
                           input logic pv, input int xx, input int yy, input int ht,
                           input int ha, input int hw, input int vt, input int va);
        vecs[i].h  = h;
        vecs[i].v  = v;
        vecs[i].b  = b;
        vecs[i].pv = pv;
        vecs[i].x  = HBITS'(xx);
        vecs[i].y  = VBITS'(yy);
        vecs[i].ht = HBITS'(ht);
        vecs[i].ha = HBITS'(ha);
        vecs[i].hw = HBITS'(hw);
        vecs[i].vt = VBITS'(vt);
        vecs[i].va = VBITS'(va);
    endtask

    function automatic logic [127:0] outs_now();
        return {51'd0, pixel_valid, x, y, htotal, hactive, hsync_width,
                vtotal, vactive, locked, timing_err};
    endfunction

    // One pixel clock of the raster generator, then sample outputs.
    task automatic gen_cycle();
        logic h, v, b, hf, vf;
        if (idle_left > 0) begin
            h = 1'b1; v = 1'b1; b = 1'b1;
        end else begin
            h = !(hc >= H_SYNC_START && hc < H_SYNC_START + H_SYNC_LEN);
            v = !(vc >= V_SYNC_START && vc < V_SYNC_START + V_SYNC_LEN);
            b = !(hc < H_ACT && vc < V_ACT);
        end
        hsync = h;
        vsync = v;
        blank = b;
        hf = prev_h & ~h;
        vf = prev_v & ~v;
        prev_h = h;
        prev_v = v;
        @(posedge vclock);
        #1;
        if (hf) begin
            hfall_cnt++;
            since_hfall = 0;
        end else begin
            since_hfall++;
        end
        if (vf) vfall_cnt++;
        if (timing_err === 1'b1) begin
            err_pulses++;
            err_since = since_hfall;
        end
        if (idle_left > 0) begin
            idle_left--;
        end else begin
            hc++;
            if (hc >= hlen) begin
                hc = 0;
                hlen = H_TOTAL;
                vc++;
                if (vc >= vlen) begin
                    vc = 0;
                    vlen = V_TOTAL;
                end
            end
        end
    endtask

    task automatic run_hfalls(input int n);
        int target, guard;
        target = hfall_cnt + n;
        guard = 0;
        while (hfall_cnt < target && guard < RUN_LIMIT) begin
            gen_cycle();
            guard++;
        end
        if (hfall_cnt < target) timeout("run_hfalls");
    endtask

    task automatic run_vfalls(input int n);
        int target, guard;
        target = vfall_cnt + n;
        guard = 0;
        while (vfall_cnt < target && guard < RUN_LIMIT) begin
            gen_cycle();
            guard++;
        end
        if (vfall_cnt < target) timeout("run_vfalls");
    endtask

    // Advance until the generator's next cycle is (tv, th).
    task automatic run_to(input int tv, input int th);
        int guard;
        guard = 0;
        while (!(vc == tv && hc == th && idle_left == 0) && guard < RUN_LIMIT) begin
            gen_cycle();
            guard++;
        end
        if (guard >= RUN_LIMIT) timeout("run_to");
    endtask

    // From a mid-frame reset release: lock at the 4th vfall, then geometry.
    task automatic lock_sequence(input string tag);
        int base;
        base = err_pulses;
        for (int n = 1; n <= 4; n++) begin
            run_vfalls(1);
            chk($sformatf("%s_locked_vfall%0d", tag, n), 128'(locked), 128'(n == 4));
        end
        chk({tag, "_vtotal"}, 128'(vtotal), 128'(V_TOTAL));
        chk({tag, "_vactive"}, 128'(vactive), 128'(V_ACT));
        run_hfalls(1);
        chk({tag, "_htotal"}, 128'(htotal), 128'(H_TOTAL));
        chk({tag, "_hactive"}, 128'(hactive), 128'(H_ACT));
        chk({tag, "_hsync_width"}, 128'(hsync_width), 128'(H_SYNC_LEN));
        chk({tag, "_no_err"}, 128'(err_pulses - base), 128'(0));
    endtask

    initial begin
        int base;
        //             h     v     b     pv    x  y  ht ha hw vt va
        set_vec(0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(1,  1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
        set_vec(2,  1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 0, 0);
        set_vec(3,  1'b1, 1'b1, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0, 0);
        set_vec(4,  1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(5,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 6, 3, 0, 0, 0);
        set_vec(6,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 6, 3, 0, 0, 0);
        set_vec(7,  1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 6, 3, 2, 0, 0);
        set_vec(8,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 6, 3, 2, 1, 1);
        set_vec(9,  1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 6, 3, 2, 1, 1);
        set_vec(10, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 6, 3, 2, 1, 1);
        set_vec(11, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 6, 3, 2, 1, 1);

        reset_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        blank = 1'b1;
        #12;
        chk("reset_outputs", outs_now(), 128'd0);
        reset_n = 1'b1;

        // Per-cycle vectors straight out of reset.
        for (int i = 0; i < 12; i++) begin
            hsync = vecs[i].h;
            vsync = vecs[i].v;
            blank = vecs[i].b;
            @(posedge vclock);
            #1;
            chk($sformatf("vec%0d", i), outs_now(),
                {51'd0, vecs[i].pv, vecs[i].x, vecs[i].y, vecs[i].ht, vecs[i].ha,
                 vecs[i].hw, vecs[i].vt, vecs[i].va, 1'b0, 1'b0});
        end

        // Mid-frame reset, then lock onto the reference raster.
        reset_n = 1'b0;
        hc = 50;
        vc = 3;
        repeat (3) gen_cycle();
        reset_n = 1'b1;
        lock_sequence("s1");

        // Coordinates at first and last active pixel of a frame.
        run_to(0, 0);
        gen_cycle();
        chk("first_pix_pv", 128'(pixel_valid), 128'(1));
        chk("first_pix_x", 128'(x), 128'(0));
        chk("first_pix_y", 128'(y), 128'(0));
        run_to(V_ACT - 1, H_ACT - 1);
        gen_cycle();
        chk("last_pix_x", 128'(x), 128'(H_ACT - 1));
        chk("last_pix_y", 128'(y), 128'(V_ACT - 1));
        chk("last_pix_pv", 128'(pixel_valid), 128'(1));
        gen_cycle();
        chk("blank_pv_x", 128'({pixel_valid, x}), 128'(0));

        // One line stretched by a cycle.
        chk("s3_pre_locked", 128'(locked), 128'(1));
        run_to(2, 0);
        hlen = H_TOTAL + 1;
        base = err_pulses;
        run_hfalls(2);
        chk("s3_err_pulse", 128'(timing_err), 128'(1));
        chk("s3_unlocked", 128'(locked), 128'(0));
        chk("s3_htotal_long", 128'(htotal), 128'(H_TOTAL + 1));
        gen_cycle();
        chk("s3_err_single", 128'(timing_err), 128'(0));
        run_hfalls(1);
        chk("s3_htotal_back", 128'(htotal), 128'(H_TOTAL));
        run_vfalls(1);
        chk("s3_locked_v1", 128'(locked), 128'(0));
        run_vfalls(1);
        chk("s3_locked_v2", 128'(locked), 128'(0));
        run_vfalls(1);
        chk("s3_locked_v3", 128'(locked), 128'(1));
        chk("s3_err_count", 128'(err_pulses - base), 128'(1));

        // hsync stuck high long enough to saturate the line counter.
        run_to(2, 0);
        idle_left = 2100;
        base = err_pulses;
        run_hfalls(1);
        chk("s4_err_count", 128'(err_pulses - base), 128'(1));
        chk("s4_err_at_sat", 128'(err_since), 128'(2047));
        chk("s4_htotal_sat", 128'(htotal), 128'(2047));
        chk("s4_unlocked", 128'(locked), 128'(0));
        run_vfalls(3);
        chk("s4_relocked", 128'(locked), 128'(1));

        // One frame short by a line.
        run_to(0, 0);
        vlen = V_TOTAL - 1;
        base = err_pulses;
        run_vfalls(2);
        chk("s5_err_pulse", 128'(timing_err), 128'(1));
        chk("s5_vtotal", 128'(vtotal), 128'(V_TOTAL - 1));
        chk("s5_unlocked", 128'(locked), 128'(0));
        chk("s5_err_count", 128'(err_pulses - base), 128'(1));
        run_vfalls(3);
        chk("s5_relocked", 128'(locked), 128'(1));

        // Asynchronous reset mid-line while locked, then relock.
        run_to(3, 30);
        chk("s6_pre_locked", 128'(locked), 128'(1));
        reset_n = 1'b0;
        #1;
        chk("s6_async_reset_outputs", outs_now(), 128'd0);
        repeat (3) gen_cycle();
        reset_n = 1'b1;
        lock_sequence("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
Receive-side counterpart of the XVGA timing generator. It samples hsync, vsync and blank in the pixel-clock domain and rebuilds the pixel coordinates. It measures line and frame geometry (total, active and sync width), declares lock once the timing is stable, and flags timing errors. It sits on the video output path, or on any incoming video stream, as a self-check and coordinate-recovery block.

Parameters:
HBITS, 11, width of horizontal counters and measurements
VBITS, 10, width of vertical counters and measurements
LOCK_FRAMES, 2, consecutive clean frames required to assert locked (1..15)

Ports:
vclock  in  1  pixel clock; sole clock
reset_n  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, active low, synchronous to vclock
vsync  in  1  vertical sync, active low, synchronous to vclock
blank  in  1  1 = blanking interval, 0 = active pixel
pixel_valid  out  1  registered ~blank
x  out  HBITS  pixel index within active line
y  out  VBITS  active-line index within frame
htotal  out  HBITS  cycles between consecutive hsync falling edges
hactive  out  HBITS  unblanked cycles in the last line that had any
hsync_width  out  HBITS  cycles hsync was low in the last pulse
vtotal  out  VBITS  hsync falling edges between consecutive vsync falling edges
vactive  out  VBITS  lines with at least one active cycle in the last frame
locked  out  1  timing stable
timing_err  out  1  one-cycle pulse on a mismatch while locked

Behaviour:
- Reset (reset_n=0, async): every output and counter is 0. The previous-sample registers hsync_d, vsync_d and blank_d are 1, so no edge is detected on release.
- Edge detection: hfall = hsync_d & ~hsync; hrise = ~hsync_d & hsync; vfall = vsync_d & ~vsync; arun_end = ~blank_d & blank. All are evaluated on raw inputs against the prior-cycle samples.
- hcnt: on hfall, htotal <= hcnt+1 and hcnt <= 0; otherwise hcnt increments, saturating at all-ones.
- swcnt: counts cycles with hsync=0; on hrise, hsync_width <= swcnt and swcnt <= 0.
- acnt: counts cycles with blank=0 in the current line. On hfall, if acnt != 0 then hactive <= acnt. acnt <= 0 on hfall; if blank=0 in the same cycle, acnt <= 1.
- vcnt: counts hfall events, saturating. On vfall, vtotal <= vcnt + hfall and vcnt <= 0, i.e. a simultaneous hfall is counted into the closing frame.
- x/y: internal xc is 0 while blank=1 and increments each blank=0 cycle. Registered outputs are pixel_valid <= ~blank and x <= xc (pre-increment value), so the first active pixel shows x=0 with 1-cycle latency. x holds 0 while blank.
- yc increments on arun_end and clears on vfall (clear wins over increment). Output y <= yc. On vfall, vactive <= yc + arun_end.
- Line mismatch:
  - on hfall, (hcnt+1) != current htotal register; or
  - hcnt reaching saturation, which fires once per saturation.
- Frame mismatch: on vfall, (vcnt+hfall) != current vtotal register; or vcnt saturation.
- Lock:
  - frame_dirty is set by any mismatch and cleared after evaluation at vfall.
  - At vfall: if the frame is clean, lockcnt increments, saturating at LOCK_FRAMES; otherwise lockcnt <= 0.
  - locked <= (lockcnt_next == LOCK_FRAMES).
  - Any mismatch while locked=1: timing_err=1 for exactly one cycle (the cycle after the edge sample); locked <= 0 and lockcnt <= 0 in the same update.
- No error is ever reported while unlocked. Measurements update regardless of lock state.
- Reset mid-frame: the first partial line and frame are measured but make frame_dirty, so no false lock occurs.

Test Plan:
- Drive a reference 1024x768 generator (1344x806, hsync low 136 cycles) from mid-frame reset → htotal=1344, hactive=1024, hsync_width=136, vtotal=806, vactive=768; locked rises at the 4th vsync falling edge; timing_err never pulses.
- Locked, observe the first active pixel of frame → pixel_valid=1, x=0, y=0 one cycle after blank falls; last pixel of line 767 shows x=1023, y=767.
- Locked, stretch one line to 1345 cycles → timing_err single pulse and locked=0 at that hfall. After the next line, htotal=1344; locked re-asserts at the 2nd vfall after the dirty frame ends.
- Locked, hold hsync high for 2100 cycles → timing_err one pulse at hcnt saturation, locked=0, htotal=2047 at the next hfall.
- Locked, drop one line (805-line frame) → timing_err at that vfall, vtotal=805, locked=0.
- Assert reset_n=0 mid-line while locked → all outputs 0 immediately (asynchronously); no spurious edge on release; relock follows the first scenario's sequence.
